// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its helpers.
//   - RV32 load/store width codes (funct3)
//   - access FSM state type
//   - data_memory size encodings
//   - access_bytes_m1(): number of bytes touched by a width code, minus one
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_SZ_BYTE = 1'b0;
  localparam logic MEM_SZ_WORD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } lsu_state_e;

  function automatic logic [1:0] access_bytes_m1(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extension: turns the raw little-endian bytes gathered from
// memory into the 32-bit register value for the given RV32 width code.
//   raw    : raw load data, LSB-aligned
//   funct3 : width code (B/H sign-extend, BU/HU zero-extend, W passthrough)
//   ext    : extended result (0 for codes that are not loads)
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ext = raw;
      F3_BU:   ext = {24'b0, raw[7:0]};
      F3_HU:   ext = {16'b0, raw[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit sitting in front of data_memory.
// Accepts one request at a time (req_valid/req_ready), checks funct3,
// alignment and range, then drives byte or word accesses on the memory
// port. Halfwords are split into two byte accesses because the memory has
// no halfword mode. The result comes back on resp_valid/resp_ready.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_*              : request handshake, store flag, width, address, data
//   resp_*             : response handshake, extended load data, error flag
//   mem_*              : data_memory port (read data is combinational)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_size,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       raw_q;
  logic              err_q;

  logic              is_word, is_half;
  logic [31:0]       ext_data;

  logic              dec_illegal, dec_misaligned, dec_range, dec_err;
  logic [ADDR_W:0]   last_byte;

  // Request decode; one extra address bit so the range check cannot wrap.
  always_comb begin
    dec_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);
    dec_misaligned = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ((req_funct3[1:0] == 2'b01) && req_addr[0]);
    last_byte      = {1'b0, req_addr} + (ADDR_W+1)'(access_bytes_m1(req_funct3));
    dec_range      = last_byte >= (ADDR_W+1)'(MEM_BYTES);
    dec_err        = dec_illegal || dec_misaligned || dec_range;
  end

  assign is_word = (funct3_q[1:0] == 2'b10);
  assign is_half = (funct3_q[1:0] == 2'b01);

  lsu_load_extend u_extend (
    .raw    (raw_q),
    .funct3 (funct3_q),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      raw_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= dec_err;
            raw_q    <= '0;
          end
        end
        ST_ACC0: begin
          if (!we_q) raw_q <= is_word ? mem_read_data : {24'b0, mem_read_data[7:0]};
        end
        ST_ACC1: begin
          if (!we_q) raw_q[15:8] <= mem_read_data[7:0];
        end
        default: ;
      endcase
    end
  end

  // Memory outputs depend only on registered state; req_* never reach them.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    mem_size       = MEM_SZ_BYTE;
    mem_address    = '0;
    mem_write_data = '0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so the unit never advertises readiness in reset.
        req_ready = rst_n;
        if (req_valid) state_d = dec_err ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_size    = is_word ? MEM_SZ_WORD : MEM_SZ_BYTE;
        mem_address = 32'(addr_q);
        mem_rd      = !we_q;
        mem_wr      = we_q;
        if (we_q) mem_write_data = is_half ? {24'b0, wdata_q[7:0]} : wdata_q;
        state_d = is_half ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        mem_size    = MEM_SZ_BYTE;
        mem_address = 32'(addr_q + ADDR_W'(1));
        mem_rd      = !we_q;
        mem_wr      = we_q;
        if (we_q) mem_write_data = {24'b0, wdata_q[15:8]};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ext_data;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
